// File: rtl/ula_flag_gen_serial.sv
// Bit-serial A-B compare engine producing diff and zero/sign/carry/overflow
// flags, one operand bit per cycle, with valid/ready handshakes on both sides.
//
// Ports:
//   i_clk, i_rst          clock (rising edge) and synchronous active-high reset
//   i_in_valid/o_in_ready operand handshake (ready only while idle)
//   i_a, i_b              minuend and subtrahend (captured on accept)
//   i_signed_mode         1: two's-complement compare, 0: unsigned compare
//   o_out_valid/i_out_ready result handshake (result held until accepted)
//   o_diff                A-B modulo 2^WIDTH
//   o_zero_flag           diff == 0
//   o_sign_flag           A < B under the captured signedness
//   o_carry_flag          carry out of A+~B+1 (1 = no borrow)
//   o_overflow_flag       signed overflow of A-B (reported in both modes)
module ula_flag_gen_serial #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_signed_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_zero_flag,
    output logic             o_sign_flag,
    output logic             o_carry_flag,
    output logic             o_overflow_flag
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_mode;
    logic             r_c;
    logic             r_zacc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic             r_zero;
    logic             r_sign;
    logic             r_carry;
    logic             r_ovf;

    logic w_nb;
    logic w_s;
    logic w_c;
    logic w_last;
    logic w_ovf;
    logic w_sign;

    // One full-adder slice of A + ~B + 1
    assign w_nb   = ~r_b[0];
    assign w_s    = r_a[0] ^ w_nb ^ r_c;
    assign w_c    = (r_a[0] & w_nb) | (r_a[0] & r_c) | (w_nb & r_c);
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // On the last bit r_c is still the carry into the MSB, so it serves
    // directly as the latched c_msb for the overflow term.
    assign w_ovf  = r_c ^ w_c;
    assign w_sign = r_mode ? (w_s ^ w_ovf) : ~w_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_mode      <= 1'b0;
            r_c         <= 1'b0;
            r_zacc      <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_mode  <= i_signed_mode;
                        r_c     <= 1'b1;
                        r_zacc  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // LSB-first: each sum bit enters at the MSB side
                    r_diff <= {w_s, r_diff[WIDTH-1:1]};
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_c    <= w_c;
                    r_zacc <= r_zacc | w_s;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_zero      <= ~(r_zacc | w_s);
                        r_carry     <= w_c;
                        r_ovf       <= w_ovf;
                        r_sign      <= w_sign;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Ready drops in the reset cycle itself and rises the cycle after
    assign o_in_ready      = (r_state == IDLE) & ~i_rst;
    assign o_out_valid     = r_out_valid;
    assign o_diff          = r_diff;
    assign o_zero_flag     = r_zero;
    assign o_sign_flag     = r_sign;
    assign o_carry_flag    = r_carry;
    assign o_overflow_flag = r_ovf;

endmodule
